data_fetch_b: RTL
=================

Name: data_fetch_b

Overview:
Consumer stage directly downstream of the request/acknowledge data source.
- Drives DataRequest and waits for Ack using a four-phase handshake.
- Captures the 8-bit Data word on each acknowledged transfer into a small first-word-fall-through FIFO.
- Exposes the FIFO to the next stage through a pop interface.
- Keeps fetching while Enable is high and the FIFO has space.

Parameters:
DEPTH, 4, FIFO entries; power of two, at least 2.
DATA_W, 8, word width; must match upstream Data.
TIMEOUT_CYCLES, 16, cycles to wait for Ack before aborting; used only with the optional feature.

Ports:
Clk  input  1  rising-edge clock.
Reset  input  1  synchronous, active-low reset (0 = reset); sampled on the rising edge of Clk.
Enable  input  1  permits new fetches to start.
Ack  input  1  upstream acknowledge; Data is valid while Ack=1.
Data  input  DATA_W  upstream data word.
DataRequest  output  1  request to upstream; registered.
Pop  input  1  next stage consumes the head word.
OutData  output  DATA_W  FIFO head word; valid when Empty=0.
Empty  output  1  FIFO holds 0 words.
Full  output  1  FIFO holds DEPTH words.
Count  output  log2(DEPTH)+1  number of words stored.
Error  output  1  sticky handshake timeout flag.

Behaviour:
- Reset (Reset=0 at a Clk edge) forces: state=IDLE, DataRequest=0, read/write pointers=0, Count=0, Empty=1, Full=0, Error=0. OutData is don't-care while Empty=1. Reset mid-transfer aborts the transfer; DataRequest is 0 in the following cycle.
- FSM states and transitions:
  - IDLE: DataRequest=0. Goes to REQ when Enable=1 && Count<DEPTH.
  - REQ: DataRequest=1. When Ack=1 is sampled: write Data at the write pointer, increment the pointer, go to RELEASE.
  - RELEASE: DataRequest=0. Waits for Ack=0, then goes to IDLE.
- Exactly one word is captured per REQ visit. A held-high Ack cannot cause a double capture, because RELEASE requires Ack=0 first.
- Enable is only checked in IDLE. Dropping Enable during REQ or RELEASE lets the transfer complete.
- Ack=1 seen while in IDLE is ignored.
- FIFO:
  - Pop && !Empty advances the read pointer.
  - Pop while Empty is ignored; Count stays 0.
  - A push (REQ capture) and a pop in the same cycle leave Count unchanged; both pointers advance.
  - Pointers wrap modulo DEPTH.
  - A push can never occur when full, because REQ is only entered with Count<DEPTH and pops only reduce Count.
- Empty = (Count==0); Full = (Count==DEPTH). Both are combinational from Count.
- Latency with a registered-Ack upstream:
  - Edge N: Enable seen in IDLE.
  - Edge N+1: DataRequest=1.
  - Ack rises one cycle later.
  - Word is written on the edge that samples Ack=1.
  - Empty falls the cycle after that edge.
  - Sustained throughput is 1 word per 5 cycles.

Optional Feature:
Macro: DATA_FETCH_B_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to REQ and increments each cycle in REQ with Ack=0.
  - When the counter reaches TIMEOUT_CYCLES, the FSM goes to IDLE without writing, DataRequest drops, and Error is set to 1.
  - Error stays 1 until reset. Fetching continues normally afterwards.
- Not defined: no counter logic; Error is tied to 0; REQ waits indefinitely.

Test Plan:
- Reset=0 for 2 cycles with Enable=1 -> DataRequest=0, Count=0, Empty=1, Full=0, Error=0 throughout.
- Enable=1, upstream model returns 8'hA5, then 8'h3C, no Pop -> two REQ/RELEASE cycles; Count=2; OutData=8'hA5; after one Pop, OutData=8'h3C.
- Enable=1, no Pop, DEPTH=4, upstream returns 8'h01..8'h04 -> Full=1 after 4th word; DataRequest stays 0; Count=4. Then Pop once -> one new fetch starts; Count returns to 4.
- Push and Pop in the same cycle with Count=2 -> Count stays 2; the order of words read out matches the write order across pointer wrap (8'h01..8'h06 in sequence).
- Ack held high for 6 cycles after capture -> only one word written; FSM stays in RELEASE until Ack=0. Reset=0 asserted during REQ -> DataRequest=0 and Count=0 the next cycle.
- With DATA_FETCH_B_TIMEOUT_EN and TIMEOUT_CYCLES=16, Ack never asserted -> DataRequest drops after 16 cycles in REQ; Error=1; Count unchanged; a later normal Ack transfer stores the word with Error still 1.

Source files
------------

// File: rtl/data_fetch_b.sv
// Four-phase request/acknowledge consumer feeding a first-word-fall-through FIFO.
// Optional handshake timeout with sticky Error is enabled by defining DATA_FETCH_B_TIMEOUT_EN.
module data_fetch_b #(
  parameter int DEPTH          = 4,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     Enable,
  input  logic                     Ack,
  input  logic [DATA_W-1:0]        Data,
  output logic                     DataRequest,
  input  logic                     Pop,
  output logic [DATA_W-1:0]        OutData,
  output logic                     Empty,
  output logic                     Full,
  output logic [$clog2(DEPTH):0]   Count,
  output logic                     Error
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [AW-1:0] PTR_ZERO  = {AW{1'b0}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t              state_q;
  logic                req_q;
  logic [AW-1:0]       wr_ptr_q;
  logic [AW-1:0]       rd_ptr_q;
  logic [CW-1:0]       count_q;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                push_s;
  logic                pop_s;
  logic                full_s;
  logic                empty_s;
  logic                timeout_s;

  assign full_s  = (count_q == DEPTH_C);
  assign empty_s = (count_q == CNT_ZERO);

  always_comb begin
    push_s = 1'b0;
    pop_s  = 1'b0;
    if (state_q == REQ) begin
      push_s = Ack;
    end else begin
      push_s = 1'b0;
    end
    if (Pop && !empty_s) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
  end

`ifdef DATA_FETCH_B_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TO_ONE  = TW'(1);

  logic [TW-1:0] to_cnt_q;
  logic          err_q;

  assign timeout_s = (state_q == REQ) && !Ack && (to_cnt_q == TO_LAST);

  // Wait counter is held at zero outside REQ so each REQ visit starts fresh.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      to_cnt_q <= {TW{1'b0}};
      err_q    <= 1'b0;
    end else begin
      if (state_q != REQ) begin
        to_cnt_q <= {TW{1'b0}};
      end else if (!Ack) begin
        to_cnt_q <= to_cnt_q + TO_ONE;
      end else begin
        to_cnt_q <= to_cnt_q;
      end
      if (timeout_s) begin
        err_q <= 1'b1;
      end else begin
        err_q <= err_q;
      end
    end
  end

  assign Error = err_q;
`else
  assign timeout_s = 1'b0;
  assign Error     = 1'b0;
`endif

  // Handshake FSM; DataRequest is registered alongside the state.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (Enable && !full_s) begin
            state_q <= REQ;
            req_q   <= 1'b1;
          end else begin
            state_q <= IDLE;
            req_q   <= 1'b0;
          end
        end
        REQ: begin
          if (Ack) begin
            state_q <= RELEASE;
            req_q   <= 1'b0;
          end else if (timeout_s) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
          end else begin
            state_q <= REQ;
            req_q   <= 1'b1;
          end
        end
        RELEASE: begin
          // Ack must drop before the next fetch, so a held Ack cannot double-capture.
          if (!Ack) begin
            state_q <= IDLE;
          end else begin
            state_q <= RELEASE;
          end
          req_q <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      wr_ptr_q <= PTR_ZERO;
      rd_ptr_q <= PTR_ZERO;
      count_q  <= CNT_ZERO;
    end else begin
      if (push_s) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_q <= wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_q <= rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array; contents need no reset since Empty masks stale words.
  always_ff @(posedge Clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= Data;
    end else begin
      mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
    end
  end

  assign DataRequest = req_q;
  assign OutData     = mem_q[rd_ptr_q];
  assign Empty       = empty_s;
  assign Full        = full_s;
  assign Count       = count_q;

endmodule
